// File: rtl/exec_div_seq.sv
// exec_div_seq: multi-cycle RV64M divide/remainder sequencer for the execute stage.
// It runs a radix-2 restoring divider, one quotient bit per cycle. The execute stage
// is stalled while the divide runs. The result is presented for one cycle (o_done).
//
// Ports:
//   i_clk        clock, rising edge
//   i_arst       asynchronous active-low reset
//   i_start      request valid, sampled only in IDLE
//   i_div_op     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_word       1 = W form (low DATA_WIDTH/2 bits, result sign-extended)
//   i_src_1      dividend
//   i_src_2      divisor
//   i_flush      abort the current operation
//   o_stall_exec hold the execute stage and earlier stages
//   o_busy       sequencer not IDLE
//   o_done       one-cycle pulse, o_result valid
//   o_result     quotient or remainder (registered)
module exec_div_seq #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_start,
    input  logic [1:0]            i_div_op,
    input  logic                  i_word,
    input  logic [DATA_WIDTH-1:0] i_src_1,
    input  logic [DATA_WIDTH-1:0] i_src_2,
    input  logic                  i_flush,
    output logic                  o_stall_exec,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int HALF  = DATA_WIDTH / 2;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // W forms sign-extend bit HALF-1 of the result, unsigned ones included.
    function automatic logic [DATA_WIDTH-1:0] fit(input logic [DATA_WIDTH-1:0] v,
                                                  input logic w);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] v,
                                                     input logic n);
        return n ? -v : v;
    endfunction

    logic [2:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            op;
    logic                  is_word;

    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;   // raw divisor until PREP, then its magnitude
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic                  neg_q;
    logic                  neg_r;

    logic                  signed_op;
    logic [DATA_WIDTH-1:0] a_ext;
    logic [DATA_WIDTH-1:0] b_ext;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] mag_a;
    logic [DATA_WIDTH-1:0] mag_b;
    logic [DATA_WIDTH-1:0] min_val;
    logic                  div_zero;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] special_res;
    logic [DATA_WIDTH-1:0] fix_res;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;
    logic                  trial_ok;

    // Operands are widened to DATA_WIDTH first (sign- or zero-extended for W forms),
    // so one set of full-width checks covers both operand sizes.
    always_comb begin
        signed_op   = ~op[0];
        a_ext       = is_word ? {{HALF{signed_op & src_a[HALF-1]}}, src_a[HALF-1:0]} : src_a;
        b_ext       = is_word ? {{HALF{signed_op & src_b[HALF-1]}}, src_b[HALF-1:0]} : src_b;
        a_neg       = signed_op & a_ext[DATA_WIDTH-1];
        b_neg       = signed_op & b_ext[DATA_WIDTH-1];
        mag_a       = neg_if(a_ext, a_neg);
        mag_b       = neg_if(b_ext, b_neg);
        min_val     = is_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                              : {1'b1, {(DATA_WIDTH-1){1'b0}}};
        div_zero    = (b_ext == '0);
        overflow    = signed_op & (a_ext == min_val) & (b_ext == '1);
        special_res = fit(op[1] ? (div_zero ? a_ext : '0) : (div_zero ? '1 : a_ext), is_word);
        fix_res     = fit(op[1] ? neg_if(rem, neg_r) : neg_if(quo, neg_q), is_word);
        shifted     = {rem, quo[DATA_WIDTH-1]};
        trial       = shifted - {1'b0, src_b};
        trial_ok    = ~trial[DATA_WIDTH];
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op       <= '0;
            is_word  <= 1'b0;
            o_result <= '0;
        end else if (i_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    op      <= i_div_op;
                    is_word <= i_word;
                    state   <= S_PREP;
                end
                S_PREP: if (div_zero | overflow) begin
                    o_result <= special_res;
                    state    <= S_DONE;
                end else begin
                    cnt   <= is_word ? CNT_W'(HALF - 1) : CNT_W'(DATA_WIDTH - 1);
                    state <= S_ITER;
                end
                S_ITER: if (cnt == '0) state <= S_FIX;
                        else           cnt   <= cnt - 1'b1;
                S_FIX: begin
                    o_result <= fix_res;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded before use.
    // W-form dividends are left-aligned in quo so the shift loop is width-agnostic:
    // after HALF steps the quotient sits in the low half and the high half is zero.
    always_ff @(posedge i_clk) begin
        case (state)
            S_IDLE: if (i_start) begin
                src_a <= i_src_1;
                src_b <= i_src_2;
            end
            S_PREP: begin
                quo   <= is_word ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
                src_b <= mag_b;
                rem   <= '0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
            end
            S_ITER: begin
                rem <= trial_ok ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
                quo <= {quo[DATA_WIDTH-2:0], trial_ok};
            end
            default: ;
        endcase
    end

    assign o_busy       = (state != S_IDLE);
    assign o_done       = (state == S_DONE) & ~i_flush;
    assign o_stall_exec = i_arst & (((state == S_IDLE) & i_start & ~i_flush) |
                                    (state == S_PREP) | (state == S_ITER) | (state == S_FIX));

endmodule
